// File: rtl/qbert_move_ctrl.sv
// qbert_move_ctrl: frame-synchronous Q*bert hop/fall position controller.
// All visible state changes on the clk edge that carries iNewFrame.
module qbert_move_ctrl #(
  parameter int unsigned ROWS        = 2,
  parameter int unsigned X_TOP       = 368,
  parameter int unsigned Y_TOP       = 100,
  parameter int unsigned HALF_W      = 64,
  parameter int unsigned ROW_H       = 96,
  parameter int unsigned HOP_FRAMES  = 8,
  parameter int unsigned LIFT        = 16,
  parameter int unsigned FALL_FRAMES = 16,
  parameter int unsigned FALL_STEP   = 24,
  localparam int unsigned NCUBE      = ROWS * (ROWS + 1) / 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             iNewFrame,
  input  logic [2:0]       iCmd,
  output logic [10:0]      oX0,
  output logic [9:0]       oY0,
  output logic [NCUBE-1:0] oCubeMask,
  output logic             oBusy,
  output logic             oFall,
  output logic             oWin
);

  localparam int unsigned XW      = 11;
  localparam int unsigned YW      = 10;
  localparam int unsigned YW1     = YW + 1;
  localparam int unsigned RW      = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned CNT_MAX = (HOP_FRAMES > FALL_FRAMES) ? HOP_FRAMES : FALL_FRAMES;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);

  localparam logic [XW-1:0]    X_STEP   = XW'(HALF_W / HOP_FRAMES);
  localparam logic [YW-1:0]    Y_STEP   = YW'(ROW_H / HOP_FRAMES);
  localparam logic [YW-1:0]    LIFT_V   = YW'(LIFT);
  localparam logic [YW1-1:0]   F_STEP   = YW1'(FALL_STEP);
  localparam logic [YW-1:0]    Y_MAX    = {YW{1'b1}};
  localparam logic [XW-1:0]    X_RST    = XW'(X_TOP);
  localparam logic [YW-1:0]    Y_RST    = YW'(Y_TOP);
  localparam logic [CW-1:0]    HOP_N    = CW'(HOP_FRAMES);
  localparam logic [CW-1:0]    HOP_HALF = CW'(HOP_FRAMES / 2);
  localparam logic [CW-1:0]    FALL_N   = CW'(FALL_FRAMES);
  localparam logic [NCUBE-1:0] MASK_RST = NCUBE'(1);

  typedef enum logic [1:0] {S_IDLE, S_HOP, S_FALL, S_WIN} state_t;

  // Exact screen anchor of a cube.
  function automatic logic [XW-1:0] base_x(input int r, input int c);
    return XW'(int'(X_TOP) + (2 * c - r) * int'(HALF_W));
  endfunction

  function automatic logic [YW-1:0] base_y(input int r);
    return YW'(int'(Y_TOP) + r * int'(ROW_H));
  endfunction

  function automatic int cube_idx(input int r, input int c);
    return r * (r + 1) / 2 + c;
  endfunction

  state_t           state_q, state_d;
  logic [RW-1:0]    row_q, row_d, col_q, col_d;
  logic [RW-1:0]    tr_q, tr_d, tc_q, tc_d;
  logic             dxn_q, dxn_d, dyn_q, dyn_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             armed_q, armed_d;
  logic [XW-1:0]    x_q, x_d;
  logic [YW-1:0]    by_q, by_d, y_q, y_d;
  logic [NCUBE-1:0] mask_q, mask_d;
  logic             busy_q, busy_d, fall_q, fall_d, win_q, win_d;

  logic             cmd_none, cmd_up, cmd_right, t_ok, accept;
  logic             do_hop, do_fall;
  logic [CW-1:0]    cnt_base;
  logic [YW1-1:0]   y_sum;
  int               t_row, t_col, hit_idx;

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      col_q   <= '0;
      tr_q    <= '0;
      tc_q    <= '0;
      dxn_q   <= 1'b0;
      dyn_q   <= 1'b0;
      cnt_q   <= '0;
      armed_q <= 1'b1;
      x_q     <= X_RST;
      by_q    <= Y_RST;
      y_q     <= Y_RST;
      mask_q  <= MASK_RST;
      busy_q  <= 1'b0;
      fall_q  <= 1'b0;
      win_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      tr_q    <= tr_d;
      tc_q    <= tc_d;
      dxn_q   <= dxn_d;
      dyn_q   <= dyn_d;
      cnt_q   <= cnt_d;
      armed_q <= armed_d;
      x_q     <= x_d;
      by_q    <= by_d;
      y_q     <= y_d;
      mask_q  <= mask_d;
      busy_q  <= busy_d;
      fall_q  <= fall_d;
      win_q   <= win_d;
    end
  end

  // Next-state: command decode, hop interpolation, fall animation.
  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    col_d    = col_q;
    tr_d     = tr_q;
    tc_d     = tc_q;
    dxn_d    = dxn_q;
    dyn_d    = dyn_q;
    cnt_d    = cnt_q;
    armed_d  = armed_q;
    x_d      = x_q;
    by_d     = by_q;
    y_d      = y_q;
    mask_d   = mask_q;
    do_hop   = 1'b0;
    do_fall  = 1'b0;
    accept   = 1'b0;
    cnt_base = cnt_q;
    y_sum    = '0;
    hit_idx  = 0;

    cmd_none  = (iCmd == 3'd0) || (iCmd > 3'd4);
    cmd_up    = (iCmd == 3'd1) || (iCmd == 3'd2);
    cmd_right = (iCmd == 3'd1) || (iCmd == 3'd3);
    t_row     = cmd_up ? int'(row_q) - 1 : int'(row_q) + 1;
    t_col     = int'(col_q) + ((iCmd == 3'd2) ? -1 : ((iCmd == 3'd3) ? 1 : 0));
    t_ok      = (t_row >= 0) && (t_row < int'(ROWS)) && (t_col >= 0) && (t_col <= t_row);

    case (state_q)
      S_IDLE: begin
        // The accepting frame is also the first animation frame.
        if (iNewFrame && armed_q && !cmd_none) begin
          accept   = 1'b1;
          cnt_base = '0;
          if (t_ok) begin
            tr_d   = RW'(t_row);
            tc_d   = RW'(t_col);
            dxn_d  = !cmd_right;
            dyn_d  = cmd_up;
            do_hop = 1'b1;
          end else begin
            do_fall = 1'b1;
          end
        end
      end
      S_HOP: begin
        if (iNewFrame) do_hop = 1'b1;
      end
      S_FALL: begin
        if (iNewFrame) begin
          if (cnt_q == FALL_N) begin
            state_d = S_IDLE;
            row_d   = '0;
            col_d   = '0;
            cnt_d   = '0;
            x_d     = X_RST;
            by_d    = Y_RST;
            y_d     = Y_RST;
            mask_d  = MASK_RST;
          end else begin
            do_fall = 1'b1;
          end
        end
      end
      S_WIN: begin
      end
      default: state_d = S_IDLE;
    endcase

    if (cmd_none) armed_d = 1'b1;
    else if (accept) armed_d = 1'b0;

    if (do_hop) begin
      state_d = S_HOP;
      cnt_d   = cnt_base + CW'(1);
      x_d     = dxn_d ? x_q - X_STEP : x_q + X_STEP;
      by_d    = dyn_d ? by_q - Y_STEP : by_q + Y_STEP;
      y_d     = (cnt_d < HOP_HALF) ? by_d - LIFT_V : by_d;
      if (cnt_d == HOP_N) begin
        row_d   = tr_d;
        col_d   = tc_d;
        cnt_d   = '0;
        x_d     = base_x(int'(tr_d), int'(tc_d));
        by_d    = base_y(int'(tr_d));
        y_d     = by_d;
        hit_idx = cube_idx(int'(tr_d), int'(tc_d));
        for (int i = 0; i < int'(NCUBE); i++) begin
          if (i == hit_idx) mask_d[i] = 1'b1;
        end
        state_d = (&mask_d) ? S_WIN : S_IDLE;
      end
    end

    if (do_fall) begin
      state_d = S_FALL;
      cnt_d   = cnt_base + CW'(1);
      y_sum   = {1'b0, y_q} + F_STEP;
      y_d     = y_sum[YW] ? Y_MAX : y_sum[YW-1:0];
    end

    busy_d = (state_d == S_HOP) || (state_d == S_FALL);
    fall_d = (state_d == S_FALL);
    win_d  = (state_d == S_WIN);
  end

  assign oX0       = x_q;
  assign oY0       = y_q;
  assign oCubeMask = mask_q;
  assign oBusy     = busy_q;
  assign oFall     = fall_q;
  assign oWin      = win_q;

endmodule

// File: tb/tb_qbert_move_ctrl.sv
// Bench for qbert_move_ctrl: frame-level behavioural model plus directed and random scenarios.
module tb_qbert_move_ctrl;

  localparam int ROWS  = 2;
  localparam int NCUBE = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic             iNewFrame;
  logic [2:0]       iCmd;
  logic [10:0]      oX0;
  logic [9:0]       oY0;
  logic [NCUBE-1:0] oCubeMask;
  logic             oBusy, oFall, oWin;
  logic [26:0]      dut_vec;

  int errors = 0;
  int checks = 0;

  // Model: mode 0=idle 1=hop 2=fall 3=win; k counts animation frames.
  int m_row, m_col, m_mask, m_mode, m_k, m_tr, m_tc, m_x, m_y;
  bit m_armed;

  qbert_move_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .iNewFrame (iNewFrame),
    .iCmd      (iCmd),
    .oX0       (oX0),
    .oY0       (oY0),
    .oCubeMask (oCubeMask),
    .oBusy     (oBusy),
    .oFall     (oFall),
    .oWin      (oWin)
  );

  always #5 clk = ~clk;

  assign dut_vec = {oX0, oY0, oCubeMask, oBusy, oFall, oWin};

  function automatic int bx(input int r, input int c);
    return 368 + (2 * c - r) * 64;
  endfunction

  function automatic int by(input int r);
    return 100 + r * 96;
  endfunction

  function automatic logic [26:0] exp_vec();
    logic b, f, w;
    b = (m_mode == 1) || (m_mode == 2);
    f = (m_mode == 2);
    w = (m_mode == 3);
    return {11'(m_x), 10'(m_y), 3'(m_mask), b, f, w};
  endfunction

  task automatic model_home();
    m_row = 0; m_col = 0; m_mask = 1; m_mode = 0; m_k = 0;
    m_x = 368; m_y = 100;
  endtask

  task automatic model_reset();
    model_home();
    m_armed = 1'b1;
    m_tr = 0; m_tc = 0;
  endtask

  // Linear interpolation between source and target anchors, lifted early in the hop.
  task automatic hop_frame();
    m_k++;
    m_x = bx(m_row, m_col) + (bx(m_tr, m_tc) - bx(m_row, m_col)) * m_k / 8;
    m_y = by(m_row) + (by(m_tr) - by(m_row)) * m_k / 8 - ((m_k < 4) ? 16 : 0);
    if (m_k == 8) begin
      m_row  = m_tr;
      m_col  = m_tc;
      m_mask = m_mask | (1 << (m_tr * (m_tr + 1) / 2 + m_tc));
      m_mode = (m_mask == 7) ? 3 : 0;
      m_k    = 0;
    end
  endtask

  task automatic fall_frame();
    m_k++;
    m_y = (m_y + 24 > 1023) ? 1023 : m_y + 24;
  endtask

  task automatic model_edge(input logic nf, input logic [2:0] cmd);
    bit none;
    int tr, tc;
    none = (cmd == 0) || (cmd > 4);
    tr = m_row; tc = m_col;
    if (nf) begin
      case (m_mode)
        0: if (m_armed && !none) begin
          m_armed = 1'b0;
          case (cmd)
            3'd1: begin tr = m_row - 1; tc = m_col;     end
            3'd2: begin tr = m_row - 1; tc = m_col - 1; end
            3'd3: begin tr = m_row + 1; tc = m_col + 1; end
            default: begin tr = m_row + 1; tc = m_col;  end
          endcase
          m_k = 0;
          if (tr >= 0 && tr < ROWS && tc >= 0 && tc <= tr) begin
            m_mode = 1; m_tr = tr; m_tc = tc;
            hop_frame();
          end else begin
            m_mode = 2;
            fall_frame();
          end
        end
        1: hop_frame();
        2: if (m_k == 16) model_home(); else fall_frame();
        default: ;
      endcase
    end
    if (none) m_armed = 1'b1;
  endtask

  task automatic tick(input logic nf, input logic [2:0] cmd);
    @(negedge clk);
    iNewFrame = nf;
    iCmd      = cmd;
    @(posedge clk);
    model_edge(nf, cmd);
    #1;
  endtask

  task automatic frame(input logic [2:0] cmd);
    tick(1'b1, cmd);
    tick(1'b0, cmd);
    tick(1'b0, cmd);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; iNewFrame = 1'b0; iCmd = 3'd0;
    #1;
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (dut_vec !== exp_vec()) begin
      errors++; $display("FAIL reset_model: got %h exp %h", dut_vec, exp_vec());
    end
    checks++;
    if (dut_vec !== {11'd368, 10'd100, 3'b001, 3'b000}) begin
      errors++; $display("FAIL reset_const: got %h exp %h", dut_vec, {11'd368, 10'd100, 3'b001, 3'b000});
    end
  endtask

  task automatic test_hop_down_right();
    do_reset();
    frame(3'd3);
    checks++;
    if (dut_vec !== {11'd376, 10'd96, 3'b001, 3'b100}) begin
      errors++; $display("FAIL hop_first_frame: got %h exp %h", dut_vec, {11'd376, 10'd96, 3'b001, 3'b100});
    end
    for (int f = 2; f <= 8; f++) begin
      frame(3'd3);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL hop_frame_%0d: got %h exp %h", f, dut_vec, exp_vec());
      end
    end
    checks++;
    if (dut_vec !== {11'd432, 10'd196, 3'b101, 3'b000}) begin
      errors++; $display("FAIL hop_land: got %h exp %h", dut_vec, {11'd432, 10'd196, 3'b101, 3'b000});
    end
    frame(3'd0);
  endtask

  task automatic test_win();
    for (int f = 1; f <= 8; f++) begin
      frame(3'd2);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL upleft_frame_%0d: got %h exp %h", f, dut_vec, exp_vec());
      end
    end
    checks++;
    if (dut_vec !== {11'd368, 10'd100, 3'b101, 3'b000}) begin
      errors++; $display("FAIL upleft_land: got %h exp %h", dut_vec, {11'd368, 10'd100, 3'b101, 3'b000});
    end
    frame(3'd0);
    for (int f = 1; f <= 8; f++) begin
      frame(3'd4);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL downleft_frame_%0d: got %h exp %h", f, dut_vec, exp_vec());
      end
    end
    checks++;
    if (dut_vec !== {11'd304, 10'd196, 3'b111, 3'b001}) begin
      errors++; $display("FAIL win_land: got %h exp %h", dut_vec, {11'd304, 10'd196, 3'b111, 3'b001});
    end
    for (int i = 0; i < 6; i++) begin
      frame((i % 2 == 0) ? 3'(i / 2 + 1) : 3'd0);
      checks++;
      if (dut_vec !== {11'd304, 10'd196, 3'b111, 3'b001}) begin
        errors++; $display("FAIL win_frozen_%0d: got %h exp %h", i, dut_vec, {11'd304, 10'd196, 3'b111, 3'b001});
      end
    end
  endtask

  task automatic test_fall();
    do_reset();
    frame(3'd1);
    checks++;
    if (dut_vec !== {11'd368, 10'd124, 3'b001, 3'b110}) begin
      errors++; $display("FAIL fall_first: got %h exp %h", dut_vec, {11'd368, 10'd124, 3'b001, 3'b110});
    end
    for (int f = 2; f <= 16; f++) begin
      frame(3'd1);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL fall_frame_%0d: got %h exp %h", f, dut_vec, exp_vec());
      end
    end
    checks++;
    if (dut_vec !== {11'd368, 10'd484, 3'b001, 3'b110}) begin
      errors++; $display("FAIL fall_bottom: got %h exp %h", dut_vec, {11'd368, 10'd484, 3'b001, 3'b110});
    end
    frame(3'd1);
    checks++;
    if (dut_vec !== {11'd368, 10'd100, 3'b001, 3'b000}) begin
      errors++; $display("FAIL fall_respawn: got %h exp %h", dut_vec, {11'd368, 10'd100, 3'b001, 3'b000});
    end
  endtask

  task automatic test_held();
    do_reset();
    for (int f = 1; f <= 30; f++) begin
      frame(3'd3);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL held_frame_%0d: got %h exp %h", f, dut_vec, exp_vec());
      end
    end
    checks++;
    if (dut_vec !== {11'd432, 10'd196, 3'b101, 3'b000}) begin
      errors++; $display("FAIL held_single_hop: got %h exp %h", dut_vec, {11'd432, 10'd196, 3'b101, 3'b000});
    end
    frame(3'd0);
    for (int f = 1; f <= 8; f++) begin
      frame(3'd2);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL rearm_frame_%0d: got %h exp %h", f, dut_vec, exp_vec());
      end
    end
    checks++;
    if (dut_vec !== {11'd368, 10'd100, 3'b101, 3'b000}) begin
      errors++; $display("FAIL rearm_land: got %h exp %h", dut_vec, {11'd368, 10'd100, 3'b101, 3'b000});
    end
  endtask

  task automatic test_no_frame();
    do_reset();
    for (int c = 1; c <= 10000; c++) begin
      tick(1'b0, 3'd3);
      if (c % 2500 == 0) begin
        checks++;
        if (dut_vec !== {11'd368, 10'd100, 3'b001, 3'b000}) begin
          errors++; $display("FAIL no_frame_%0d: got %h exp %h", c, dut_vec, {11'd368, 10'd100, 3'b001, 3'b000});
        end
      end
    end
  endtask

  task automatic test_reset_mid_hop();
    do_reset();
    for (int f = 1; f <= 4; f++) frame(3'd3);
    checks++;
    if (dut_vec !== exp_vec()) begin
      errors++; $display("FAIL pre_reset_hop: got %h exp %h", dut_vec, exp_vec());
    end
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    checks++;
    if (dut_vec !== {11'd368, 10'd100, 3'b001, 3'b000}) begin
      errors++; $display("FAIL mid_hop_reset: got %h exp %h", dut_vec, {11'd368, 10'd100, 3'b001, 3'b000});
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_random();
    logic [2:0] cmd;
    logic       nf;
    do_reset();
    cmd = 3'd0;
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 5) == 0) cmd = 3'($urandom_range(0, 7));
      nf = ($urandom_range(0, 3) == 0);
      tick(nf, cmd);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL random_%0d: got %h exp %h", n, dut_vec, exp_vec());
      end
      if ((m_mode == 3 && $urandom_range(0, 9) == 0) || $urandom_range(0, 399) == 0) begin
        do_reset();
        cmd = 3'd0;
      end
    end
  endtask

  initial begin
    reset = 1'b1; iNewFrame = 1'b0; iCmd = 3'd0;
    model_reset();
    test_reset();
    test_hop_down_right();
    test_win();
    test_fall();
    test_held();
    test_no_frame();
    test_reset_mid_hop();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
